// File: rtl/boot_loader.sv
// Byte-stream boot loader: assembles little-endian 32-bit words and writes them into the icache boot port.
// Optional trailing XOR checksum is enabled by defining BOOT_LOADER_CHKSUM_EN.
module boot_loader #(
    parameter int ADDR_W  = 8,
    parameter int WEB_LEN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              boot_up,
    output logic [ADDR_W-1:0] boot_addr,
    output logic [31:0]       boot_datai,
    output logic              boot_web,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
`ifdef BOOT_LOADER_CHKSUM_EN
        ST_CHK   = 3'd4,
`endif
        ST_FIN   = 3'd5
    } state_t;

    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t              state_r;
    state_t              state_nx_s;
    logic                ready_nx_s;
    logic                accept_s;
    logic                last_beat_s;
    logic                in_ready_r;
    logic                boot_up_r;
    logic [ADDR_W-1:0]   boot_addr_r;
    logic [31:0]         boot_datai_r;
    logic                boot_web_r;
    logic                done_r;
    logic                err_r;
    logic [23:0]         word_r;
    logic [1:0]          byte_idx_r;
    logic [8:0]          words_left_r;
    logic [1:0]          web_cnt_r;
    logic                addr_inc_r;
`ifdef BOOT_LOADER_CHKSUM_EN
    logic [7:0]          chk_r;
`endif

    assign accept_s    = in_valid & in_ready_r;
    assign last_beat_s = (web_cnt_r == 2'(WEB_LEN - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode and the in_ready value for the coming state.
    always_comb begin
        state_nx_s = state_r;
        ready_nx_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nx_s = ST_HDR;
                else       state_nx_s = ST_IDLE;
            end
            ST_HDR: begin
                if (accept_s) state_nx_s = ST_DATA;
                else          state_nx_s = ST_HDR;
            end
            ST_DATA: begin
                if (accept_s && (byte_idx_r == 2'd3)) state_nx_s = ST_WRITE;
                else                                  state_nx_s = ST_DATA;
            end
            ST_WRITE: begin
                if (!last_beat_s) begin
                    state_nx_s = ST_WRITE;
                end else if (words_left_r == 9'd1) begin
`ifdef BOOT_LOADER_CHKSUM_EN
                    state_nx_s = ST_CHK;
`else
                    state_nx_s = ST_FIN;
`endif
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
`ifdef BOOT_LOADER_CHKSUM_EN
            // A bad checksum parks in IDLE with boot_up still high so the core stays in reset.
            ST_CHK: begin
                if (!accept_s)               state_nx_s = ST_CHK;
                else if (in_data == chk_r)   state_nx_s = ST_FIN;
                else                         state_nx_s = ST_IDLE;
            end
`endif
            ST_FIN:  state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
`ifdef BOOT_LOADER_CHKSUM_EN
        if (state_nx_s == ST_HDR || state_nx_s == ST_DATA || state_nx_s == ST_CHK) ready_nx_s = 1'b1;
        else                                                                       ready_nx_s = 1'b0;
`else
        if (state_nx_s == ST_HDR || state_nx_s == ST_DATA) ready_nx_s = 1'b1;
        else                                               ready_nx_s = 1'b0;
`endif
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r   <= 1'b0;
            boot_up_r    <= 1'b0;
            boot_addr_r  <= '0;
            boot_datai_r <= 32'd0;
            boot_web_r   <= 1'b1;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            word_r       <= 24'd0;
            byte_idx_r   <= 2'd0;
            words_left_r <= 9'd0;
            web_cnt_r    <= 2'd0;
            addr_inc_r   <= 1'b0;
`ifdef BOOT_LOADER_CHKSUM_EN
            chk_r        <= 8'd0;
`endif
        end else begin
            in_ready_r <= ready_nx_s;
            boot_web_r <= (state_nx_s != ST_WRITE);
            // Address advances one cycle after boot_web rises so the write address is held past the edge.
            if (addr_inc_r) begin
                boot_addr_r <= boot_addr_r + ADDR_W'(1);
                addr_inc_r  <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        boot_up_r <= 1'b1;
                        done_r    <= 1'b0;
                        err_r     <= 1'b0;
`ifdef BOOT_LOADER_CHKSUM_EN
                        chk_r     <= 8'd0;
`endif
                    end
                end
                ST_HDR: begin
                    if (accept_s) begin
                        words_left_r <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                        boot_addr_r  <= '0;
                        byte_idx_r   <= 2'd0;
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        byte_idx_r <= byte_idx_r + 2'd1;
`ifdef BOOT_LOADER_CHKSUM_EN
                        chk_r      <= chk_update(chk_r, in_data);
`endif
                        case (byte_idx_r)
                            2'd0:    word_r[7:0]   <= in_data;
                            2'd1:    word_r[15:8]  <= in_data;
                            2'd2:    word_r[23:16] <= in_data;
                            default: begin
                                boot_datai_r <= {in_data, word_r};
                                web_cnt_r    <= 2'd0;
                            end
                        endcase
                    end
                end
                ST_WRITE: begin
                    web_cnt_r <= web_cnt_r + 2'd1;
                    if (last_beat_s) begin
                        words_left_r <= words_left_r - 9'd1;
                        addr_inc_r   <= 1'b1;
                    end
                end
`ifdef BOOT_LOADER_CHKSUM_EN
                ST_CHK: begin
                    if (accept_s && (in_data != chk_r)) begin
                        err_r  <= 1'b1;
                        done_r <= 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
            if (state_nx_s == ST_FIN) begin
                boot_up_r <= 1'b0;
                done_r    <= 1'b1;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign boot_up    = boot_up_r;
    assign boot_addr  = boot_addr_r;
    assign boot_datai = boot_datai_r;
    assign boot_web   = boot_web_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader (default WEB_LEN=1); checksum case runs when
// BOOT_LOADER_CHKSUM_EN is defined.
module tb_boot_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        boot_up;
    logic [7:0]  boot_addr;
    logic [31:0] boot_datai;
    logic        boot_web;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          ir_err   = 0;
    int          stab_err = 0;
    logic        prev_web;
    logic [7:0]  prev_addr;
    logic [31:0] prev_data;

    boot_loader #(.ADDR_W(8), .WEB_LEN(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .boot_up(boot_up), .boot_addr(boot_addr), .boot_datai(boot_datai),
        .boot_web(boot_web), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor: logs each low boot_web cycle and watches handshake/hold rules.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!boot_web) begin
                wr_addr_q.push_back(boot_addr);
                wr_data_q.push_back(boot_datai);
                if (in_ready) ir_err++;
            end
            if (prev_web == 1'b0 && boot_web == 1'b1 &&
                (boot_addr != prev_addr || boot_datai != prev_data)) stab_err++;
        end
        prev_web  = boot_web;
        prev_addr = boot_addr;
        prev_data = boot_datai;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int n = 0; n < 50; n++) begin
            if (in_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("byte_accept", 32'(ok), 32'd1);
        if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        send_byte(w[7:0], gap);
        send_byte(w[15:8], gap);
        send_byte(w[23:16], gap);
        send_byte(w[31:24], gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        for (int n = 0; n < bound; n++) begin
            if (done) break;
            @(negedge clk);
        end
        check_eq(tag, 32'(done), 32'd1);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        ir_err   = 0;
        stab_err = 0;
    endtask

    logic [31:0] t2_w[3];
    logic [31:0] w;
    logic [7:0]  ib;

    initial begin
        t2_w[0] = 32'h04030201;
        t2_w[1] = 32'hA1B2C3D4;
        t2_w[2] = 32'hDEADBEEF;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_boot_up", 32'(boot_up), 32'd0);
        check_eq("rst_addr", 32'(boot_addr), 32'd0);
        check_eq("rst_datai", boot_datai, 32'd0);
        check_eq("rst_web", 32'(boot_web), 32'd1);
        check_eq("rst_ready", 32'(in_ready), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: single word.
        clear_log();
        pulse_start();
        check_eq("t1_boot_up", 32'(boot_up), 32'd1);
        check_eq("t1_hdr_ready", 32'(in_ready), 32'd1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h78, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b0);
        in_valid = 1'b0;
        check_eq("t1_web_low", 32'(boot_web), 32'd0);
        check_eq("t1_addr", 32'(boot_addr), 32'd0);
        check_eq("t1_datai", boot_datai, 32'h12345678);
        check_eq("t1_ready_write", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_eq("t1_web_high", 32'(boot_web), 32'd1);
        check_eq("t1_done", 32'(done), 32'd1);
        check_eq("t1_boot_up_low", 32'(boot_up), 32'd0);
        check_eq("t1_err", 32'(err), 32'd0);
        check_eq("t1_nwrites", wr_addr_q.size(), 32'd1);
        @(negedge clk);

        // Test 2: three words with in_valid toggling.
        clear_log();
        pulse_start();
        check_eq("t2_done_cleared", 32'(done), 32'd0);
        send_byte(8'h03, 1'b1);
        for (int i = 0; i < 3; i++) send_word(t2_w[i], 1'b1);
        wait_done("t2_done", 20);
        check_eq("t2_nwrites", wr_addr_q.size(), 32'd3);
        for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
            check_eq($sformatf("t2_addr%0d", i), 32'(wr_addr_q[i]), 32'(i));
            check_eq($sformatf("t2_data%0d", i), wr_data_q[i], t2_w[i]);
        end
        check_eq("t2_ready_in_write", ir_err, 32'd0);
        check_eq("t2_hold", stab_err, 32'd0);
        @(negedge clk);

        // Test 3: header 00 -> 256 words.
        clear_log();
        pulse_start();
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 256; i++) begin
            ib = 8'(i);
            send_word({ib, ~ib, 8'h3C, ib ^ 8'hA5}, 1'b0);
        end
        in_valid = 1'b0;
        wait_done("t3_done", 20);
        @(negedge clk);
        check_eq("t3_nwrites", wr_addr_q.size(), 32'd256);
        for (int i = 0; i < 256 && i < wr_addr_q.size(); i++) begin
            ib = 8'(i);
            check_eq($sformatf("t3_addr%0d", i), 32'(wr_addr_q[i]), 32'(i));
            check_eq($sformatf("t3_data%0d", i), wr_data_q[i], {ib, ~ib, 8'h3C, ib ^ 8'hA5});
        end
        check_eq("t3_addr_wrap", 32'(boot_addr), 32'd0);
        check_eq("t3_hold", stab_err, 32'd0);

        // Test 4: asynchronous reset mid-word, then clean reload.
        clear_log();
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("t4_boot_up", 32'(boot_up), 32'd0);
        check_eq("t4_datai", boot_datai, 32'd0);
        check_eq("t4_web", 32'(boot_web), 32'd1);
        check_eq("t4_ready", 32'(in_ready), 32'd0);
        check_eq("t4_done", 32'(done), 32'd0);
        check_eq("t4_addr", 32'(boot_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_word(32'hCAFEBABE, 1'b0);
        in_valid = 1'b0;
        wait_done("t4_done_reload", 20);
        check_eq("t4_nwrites", wr_addr_q.size(), 32'd1);
        if (wr_addr_q.size() > 0) begin
            check_eq("t4_w_addr", 32'(wr_addr_q[0]), 32'd0);
            check_eq("t4_w_data", wr_data_q[0], 32'hCAFEBABE);
        end
        @(negedge clk);

        // Test 5: start during DATA is ignored; start+valid in IDLE does not consume the byte.
        clear_log();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        in_valid = 1'b0;
        pulse_start();
        check_eq("t5_ready_data", 32'(in_ready), 32'd1);
        check_eq("t5_boot_up", 32'(boot_up), 32'd1);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        in_valid = 1'b0;
        wait_done("t5_done1", 20);
        check_eq("t5_nwrites1", wr_addr_q.size(), 32'd1);
        if (wr_data_q.size() > 0) check_eq("t5_data1", wr_data_q[0], 32'h44332211);
        @(negedge clk);
        clear_log();
        start = 1'b1; in_valid = 1'b1; in_data = 8'h02;
        check_eq("t5_idle_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check_eq("t5_hdr_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        send_word(32'h87654321, 1'b0);
        send_word(32'h0F1E2D3C, 1'b0);
        in_valid = 1'b0;
        wait_done("t5_done2", 20);
        check_eq("t5_nwrites2", wr_addr_q.size(), 32'd2);
        if (wr_data_q.size() > 1) begin
            check_eq("t5_data2a", wr_data_q[0], 32'h87654321);
            check_eq("t5_data2b", wr_data_q[1], 32'h0F1E2D3C);
            check_eq("t5_addr2b", 32'(wr_addr_q[1]), 32'd1);
        end
        check_eq("t5_err", 32'(err), 32'd0);
        @(negedge clk);

`ifdef BOOT_LOADER_CHKSUM_EN
        // Test 6: checksum match then mismatch.
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_word(32'h44332211, 1'b0);
        send_byte(8'h44, 1'b0);
        in_valid = 1'b0;
        wait_done("t6_done_ok", 20);
        @(negedge clk);
        check_eq("t6_err_ok", 32'(err), 32'd0);
        check_eq("t6_boot_up_ok", 32'(boot_up), 32'd0);
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_word(32'h44332211, 1'b0);
        send_byte(8'h00, 1'b0);
        in_valid = 1'b0;
        wait_done("t6_done_bad", 20);
        repeat (3) @(negedge clk);
        check_eq("t6_err_bad", 32'(err), 32'd1);
        check_eq("t6_done_bad_hold", 32'(done), 32'd1);
        check_eq("t6_boot_up_bad", 32'(boot_up), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
